// File: rtl/frame_checker.sv
// Receive-side frame checker: validates Ethernet/IPv4 header fields and length of returning
// frames against the port configuration and keeps good/bad frame and good-byte counters.
package frame_checker_pkg;
   typedef struct packed {
      logic        enable;
      logic [15:0] frame_size;
      logic [31:0] src_ip;
      logic [31:0] dst_ip;
      logic [47:0] src_mac;
      logic [47:0] dst_mac;
   } port_config_t;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

module frame_checker
   import frame_checker_pkg::*;
#(
   parameter int CNT_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   input  port_config_t         port_config,
   input  logic [7:0]           axis_s_data,
   input  logic                 axis_s_valid,
   input  logic                 axis_s_last,
   input  logic                 axis_s_user,
   output logic                 axis_s_ready,
   output logic                 running,
   output logic [CNT_WIDTH-1:0] frames_ok,
   output logic [CNT_WIDTH-1:0] frames_err,
   output logic [CNT_WIDTH-1:0] bytes_ok
);

   localparam int HDR_BYTES = 34;
   // One bit per header byte (MSB = byte 0): dst MAC bytes 6..11 and bytes 15..25 are not compared.
   localparam logic [HDR_BYTES-1:0] CHECK_MASK = {6'b111111, 6'b000000, 3'b111, 11'b0, 8'hFF};

   state_t      state, state_next;
   logic        mid_frame;
   logic        tracked;
   logic        err_flag;
   logic [15:0] byte_idx;

   logic                   beat;
   logic                   first_beat;
   logic                   frame_live;
   logic                   count_now;
   logic                   next_frame_open;
   logic                   byte_bad;
   logic                   frame_bad;
   logic [16:0]            frame_len;
   logic [5:0]             hdr_pos;
   logic [HDR_BYTES*8-1:0] hdr_exp;

   assign beat       = axis_s_valid && axis_s_ready;
   assign first_beat = beat && !mid_frame;
   assign running    = (state != IDLE);

   // Expected header image in wire order; unchecked bytes are zero and masked out.
   assign hdr_exp = {port_config.src_mac, 48'h0, 16'h0800, 8'h45, 88'h0,
                     port_config.dst_ip, port_config.src_ip};
   assign hdr_pos = 6'd33 - byte_idx[5:0];

   assign byte_bad  = beat && (byte_idx < 16'(HDR_BYTES)) && CHECK_MASK[hdr_pos]
                      && (axis_s_data != hdr_exp[8*hdr_pos +: 8]);
   assign frame_len = {1'b0, byte_idx} + 17'd1;
   assign frame_bad = err_flag || byte_bad || (byte_idx < 16'(HDR_BYTES - 1))
                      || (frame_len != {1'b0, port_config.frame_size}) || axis_s_user;

   // A frame is measured only if its first byte arrived in RUN with the port enabled.
   assign frame_live      = mid_frame ? tracked : (state == RUN && port_config.enable);
   assign count_now       = beat && axis_s_last && frame_live && !start;
   assign next_frame_open = beat ? !axis_s_last : mid_frame;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = RUN;
         RUN: begin
            if (start)     state_next = RUN;
            else if (stop) state_next = next_frame_open ? DRAIN : IDLE;
         end
         DRAIN: begin
            if (start)                     state_next = RUN;
            else if (beat && axis_s_last)  state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         axis_s_ready <= 1'b0;
         mid_frame    <= 1'b0;
         tracked      <= 1'b0;
         err_flag     <= 1'b0;
         byte_idx     <= '0;
      end else begin
         state        <= state_next;
         axis_s_ready <= 1'b1;
         if (beat) begin
            mid_frame <= !axis_s_last;
            err_flag  <= axis_s_last ? 1'b0 : (err_flag || byte_bad);
            if (axis_s_last)             byte_idx <= '0;
            else if (byte_idx != 16'hFFFF) byte_idx <= byte_idx + 16'd1;
         end
         if (start)                          tracked <= 1'b0;
         else if (first_beat && !axis_s_last) tracked <= frame_live;
         else if (beat && axis_s_last)       tracked <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || start) begin
         frames_ok  <= '0;
         frames_err <= '0;
         bytes_ok   <= '0;
      end else if (count_now) begin
         if (frame_bad) begin
            frames_err <= frames_err + 1'b1;
         end else begin
            frames_ok <= frames_ok + 1'b1;
            bytes_ok  <= bytes_ok + CNT_WIDTH'(frame_len);
         end
      end
   end

endmodule

// File: tb/tb_frame_checker.sv
// Directed bench for frame_checker: a vector table of single-frame cases plus hand-written
// sequences for back-to-back traffic, start/stop timing, reset mid-frame and valid gaps.
module tb_frame_checker;
   import frame_checker_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         start, stop;
   port_config_t cfg;
   logic [7:0]   axis_s_data;
   logic         axis_s_valid, axis_s_last, axis_s_user, axis_s_ready;
   logic         running;
   logic [63:0]  frames_ok, frames_err, bytes_ok;

   int n_checks = 0;
   int n_errors = 0;
   int ready_drops = 0;
   logic mon_ready = 1'b0;

   frame_checker #(.CNT_WIDTH(64)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .port_config(cfg),
      .axis_s_data(axis_s_data), .axis_s_valid(axis_s_valid), .axis_s_last(axis_s_last),
      .axis_s_user(axis_s_user), .axis_s_ready(axis_s_ready), .running(running),
      .frames_ok(frames_ok), .frames_err(frames_err), .bytes_ok(bytes_ok)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (mon_ready && !axis_s_ready) ready_drops++;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      int         len;
      int         fsize;
      logic       en;
      int         bad_idx;
      logic [7:0] mask;
      logic       user;
      int         e_ok;
      int         e_err;
      int         e_bytes;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] good_byte(input int i);
      if (i < 6)                 return cfg.src_mac[8*(5-i) +: 8];
      else if (i < 12)           return cfg.dst_mac[8*(11-i) +: 8];
      else if (i == 12)          return 8'h08;
      else if (i == 13)          return 8'h00;
      else if (i == 14)          return 8'h45;
      else if (i >= 26 && i < 30) return cfg.dst_ip[8*(29-i) +: 8];
      else if (i >= 30 && i < 34) return cfg.src_ip[8*(33-i) +: 8];
      else                       return 8'(i) ^ 8'h5A;
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_frame(input int len, input int bad_idx, input logic [7:0] mask,
                             input logic user, input logic gaps, input int start_at,
                             input int stop_at, input int rst_at);
      for (int i = 0; i < len; i++) begin
         if (gaps) begin
            int n_idle;
            n_idle = $urandom_range(0, 2);
            for (int g = 0; g < n_idle; g++) begin
               axis_s_valid = 1'b0;
               @(posedge clk); #1;
            end
         end
         axis_s_data  = good_byte(i) ^ ((i == bad_idx) ? mask : 8'h00);
         axis_s_valid = 1'b1;
         axis_s_last  = (i == len - 1);
         axis_s_user  = (i == len - 1) ? user : 1'b0;
         start        = (i == start_at);
         stop         = (i == stop_at);
         rst          = (i == rst_at);
         @(posedge clk); #1;
         start = 1'b0;
         stop  = 1'b0;
         rst   = 1'b0;
         if (i == stop_at && i < len - 1) check("drain_running", 64'(running), 64'd1);
      end
      axis_s_valid = 1'b0;
      axis_s_last  = 1'b0;
      axis_s_user  = 1'b0;
   endtask

   task automatic send_good(input int n);
      for (int k = 0; k < n; k++) send_frame(60, -1, 8'h00, 1'b0, 1'b0, -1, -1, -1);
   endtask

   task automatic check_counts(input string tag, input int e_ok, input int e_err, input int e_bytes);
      @(negedge clk);
      check({tag, "_frames_ok"}, frames_ok, 64'(e_ok));
      check({tag, "_frames_err"}, frames_err, 64'(e_err));
      check({tag, "_bytes_ok"}, bytes_ok, 64'(e_bytes));
   endtask

   initial begin
      cfg = '{enable: 1'b1, frame_size: 16'd60, src_ip: 32'h0A00_0001, dst_ip: 32'h0A00_0002,
              src_mac: 48'h0200_0000_0001, dst_mac: 48'h0200_0000_0002};
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      axis_s_data = 8'h00; axis_s_valid = 1'b0; axis_s_last = 1'b0; axis_s_user = 1'b0;

      //           len fsz en  idx  mask  usr ok err bytes
      vecs[0]  = '{60, 60, 1'b1, -1, 8'h00, 1'b0, 1, 0, 60};
      vecs[1]  = '{60, 60, 1'b1, 13, 8'h06, 1'b0, 0, 1, 0};
      vecs[2]  = '{60, 60, 1'b1,  5, 8'hFF, 1'b0, 0, 1, 0};
      vecs[3]  = '{59, 60, 1'b1, -1, 8'h00, 1'b0, 0, 1, 0};
      vecs[4]  = '{61, 60, 1'b1, -1, 8'h00, 1'b0, 0, 1, 0};
      vecs[5]  = '{60, 60, 1'b1, -1, 8'h00, 1'b1, 0, 1, 0};
      vecs[6]  = '{60, 60, 1'b1, 14, 8'h01, 1'b0, 0, 1, 0};
      vecs[7]  = '{60, 60, 1'b1, 12, 8'h08, 1'b0, 0, 1, 0};
      vecs[8]  = '{60, 60, 1'b1, 29, 8'h01, 1'b0, 0, 1, 0};
      vecs[9]  = '{60, 60, 1'b1, 33, 8'h80, 1'b0, 0, 1, 0};
      vecs[10] = '{60, 60, 1'b1, 40, 8'hFF, 1'b0, 1, 0, 60};
      vecs[11] = '{ 1, 60, 1'b1, -1, 8'h00, 1'b0, 0, 1, 0};
      vecs[12] = '{20, 20, 1'b1, -1, 8'h00, 1'b0, 0, 1, 0};
      vecs[13] = '{34, 34, 1'b1, -1, 8'h00, 1'b0, 1, 0, 34};
      vecs[14] = '{60, 60, 1'b0, -1, 8'h00, 1'b0, 0, 0, 0};
      vecs[15] = '{60, 60, 1'b1,  6, 8'hFF, 1'b0, 1, 0, 60};
      vecs[16] = '{60, 60, 1'b1, 26, 8'h01, 1'b0, 0, 1, 0};

      // Reset state
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      check("reset_ready", 64'(axis_s_ready), 64'd0);
      check("reset_running", 64'(running), 64'd0);
      check_counts("reset", 0, 0, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      check("ready_after_reset", 64'(axis_s_ready), 64'd1);
      check("idle_running", 64'(running), 64'd0);

      // Ten back-to-back good frames
      pulse_start();
      check("start_running", 64'(running), 64'd1);
      send_good(10);
      check_counts("b2b", 10, 0, 600);

      // Errors accumulate across frames
      pulse_start();
      send_frame(60, 13, 8'h06, 1'b0, 1'b0, -1, -1, -1);
      check_counts("type_err", 0, 1, 0);
      send_frame(60, 5, 8'hFF, 1'b0, 1'b0, -1, -1, -1);
      check_counts("mac_err", 0, 2, 0);

      // Single-frame vector table
      for (int v = 0; v < 17; v++) begin
         cfg.frame_size = 16'(vecs[v].fsize);
         cfg.enable     = vecs[v].en;
         pulse_start();
         send_frame(vecs[v].len, vecs[v].bad_idx, vecs[v].mask, vecs[v].user, 1'b0, -1, -1, -1);
         check_counts($sformatf("vec%0d", v), vecs[v].e_ok, vecs[v].e_err, vecs[v].e_bytes);
      end
      cfg.frame_size = 16'd60;
      cfg.enable     = 1'b1;

      // Stop on byte 30: frame drains and counts, later frames ignored
      pulse_start();
      send_frame(60, -1, 8'h00, 1'b0, 1'b0, -1, 30, -1);
      @(negedge clk);
      check("stop_idle_running", 64'(running), 64'd0);
      check_counts("stop", 1, 0, 60);
      send_good(2);
      check_counts("after_stop", 1, 0, 60);

      // Start on byte 20 from IDLE: that frame is dropped, next one counts
      send_frame(60, -1, 8'h00, 1'b0, 1'b0, 20, -1, -1);
      @(negedge clk);
      check("midstart_running", 64'(running), 64'd1);
      check_counts("midstart", 0, 0, 0);
      send_good(1);
      check_counts("midstart_next", 1, 0, 60);

      // Start while RUN mid-frame discards the frame and clears counters
      send_frame(60, -1, 8'h00, 1'b0, 1'b0, 10, -1, -1);
      check_counts("restart", 0, 0, 0);

      // Reset mid-frame: everything back to reset, remainder discarded
      send_good(1);
      send_frame(60, -1, 8'h00, 1'b0, 1'b0, -1, -1, 30);
      @(negedge clk);
      check("rst_mid_running", 64'(running), 64'd0);
      check_counts("rst_mid", 0, 0, 0);
      pulse_start();
      send_good(1);
      check_counts("rst_recover", 1, 0, 60);

      // 100 good frames with random valid gaps
      pulse_start();
      mon_ready = 1'b1;
      for (int k = 0; k < 100; k++) send_frame(60, -1, 8'h00, 1'b0, 1'b1, -1, -1, -1);
      @(negedge clk);
      mon_ready = 1'b0;
      check("ready_drops", 64'(ready_drops), 64'd0);
      check_counts("gaps", 100, 0, 6000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
